// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer at the front of the 16-bit core pipeline. It
// owns the fetch PC, runs a req/ack handshake to instruction memory and drives
// the instruction register's load port (Wen / inst_in). A fetched word is held
// in IR until the decoder consumes it. A taken branch/jump squashes IR to NOP
// and restarts fetching at the new target.
//
// Configuration macro:
//   FETCH_PREFETCH_BUF_EN  - when defined, adds a one-entry prefetch buffer so
//                            the next instruction can be fetched while IR is
//                            still occupied (sustains 1 instr/cycle). When
//                            undefined, fetching stops while IR is full
//                            (at most 1 instr / 2 cycles).
//
// Parameters:
//   PC_W      fetch PC / imem address width (halfword addressing, +1 per instr)
//   RESET_PC  fetch address after reset
//   NOP_INST  word written into IR on a redirect squash
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous active-high reset
//   imem_req     out  fetch request, held until imem_ack or abandon on redirect
//   imem_addr    out  fetch address (= fetch PC)
//   imem_ack     in   imem_rdata valid this cycle for the current imem_addr
//   imem_rdata   in   instruction word from imem
//   ir_wen       out  IR load enable
//   ir_data      out  IR load data (imem_rdata when ir_wen is low)
//   ir_valid     out  IR holds a live, unconsumed instruction
//   pc_out       out  address of the instruction currently in IR
//   dec_ready    in   decoder consumes IR this cycle (meaningful with ir_valid)
//   stall        in   pipeline stall, blocks consumption
//   redirect     in   branch/jump taken: flush IR and refetch
//   redirect_pc  in   new fetch address
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter logic [15:0]     NOP_INST = 16'h4300
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            ir_wen,
  output logic [15:0]     ir_data,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc_out,
  input  logic            dec_ready,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PC_W-1:0] fetch_pc_r;
  logic [PC_W-1:0] fetch_pc_nxt_s;
  logic [PC_W-1:0] pc_out_r;
  logic [PC_W-1:0] pc_out_nxt_s;
  logic            ir_valid_r;
  logic            ir_valid_nxt_s;
  logic            imem_req_s;
  logic            ir_wen_s;
  logic [15:0]     ir_data_s;
  logic            consume_s;

`ifdef FETCH_PREFETCH_BUF_EN
  logic [15:0]     buf_data_r;
  logic [15:0]     buf_data_nxt_s;
  logic [PC_W-1:0] buf_pc_r;
  logic [PC_W-1:0] buf_pc_nxt_s;
  logic            buf_valid_r;
  logic            buf_valid_nxt_s;
`endif

  assign consume_s = ir_valid_r & dec_ready & ~stall;

  // Request strobe: always asserted in REQ (also during an abandoning
  // redirect); in FULL only when the prefetch buffer has room.
  always_comb begin
    imem_req_s = 1'b0;
    case (state_r)
      ST_IDLE: imem_req_s = 1'b0;
      ST_REQ:  imem_req_s = 1'b1;
`ifdef FETCH_PREFETCH_BUF_EN
      ST_FULL: imem_req_s = ~buf_valid_r;
`else
      ST_FULL: imem_req_s = 1'b0;
`endif
      default: imem_req_s = 1'b0;
    endcase
  end

  // Next-state, next-register values and IR load port.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    pc_out_nxt_s   = pc_out_r;
    ir_valid_nxt_s = ir_valid_r;
    ir_wen_s       = 1'b0;
    ir_data_s      = imem_rdata;
`ifdef FETCH_PREFETCH_BUF_EN
    buf_data_nxt_s  = buf_data_r;
    buf_pc_nxt_s    = buf_pc_r;
    buf_valid_nxt_s = buf_valid_r;
`endif

    // Redirect outranks everything outside IDLE: any ack or consume in the
    // same cycle is dropped and IR is overwritten with a NOP.
    if (redirect && (state_r != ST_IDLE)) begin
      ir_wen_s       = 1'b1;
      ir_data_s      = NOP_INST;
      fetch_pc_nxt_s = redirect_pc;
      ir_valid_nxt_s = 1'b0;
      state_nxt_s    = ST_REQ;
`ifdef FETCH_PREFETCH_BUF_EN
      buf_valid_nxt_s = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_REQ;
        end

        ST_REQ: begin
          if (imem_ack) begin
            ir_wen_s       = 1'b1;
            ir_data_s      = imem_rdata;
            pc_out_nxt_s   = fetch_pc_r;
            fetch_pc_nxt_s = fetch_pc_r + PC_ONE;
            ir_valid_nxt_s = 1'b1;
            state_nxt_s    = ST_FULL;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end

        ST_FULL: begin
`ifdef FETCH_PREFETCH_BUF_EN
          // An ack only counts while the request is up, i.e. buffer empty.
          if (consume_s) begin
            if (buf_valid_r) begin
              // Buffered word moves into IR; IR stays live.
              ir_wen_s        = 1'b1;
              ir_data_s       = buf_data_r;
              pc_out_nxt_s    = buf_pc_r;
              buf_valid_nxt_s = 1'b0;
              state_nxt_s     = ST_FULL;
            end else if (imem_ack) begin
              // Returning word bypasses the empty buffer straight into IR.
              ir_wen_s       = 1'b1;
              ir_data_s      = imem_rdata;
              pc_out_nxt_s   = fetch_pc_r;
              fetch_pc_nxt_s = fetch_pc_r + PC_ONE;
              state_nxt_s    = ST_FULL;
            end else begin
              ir_valid_nxt_s = 1'b0;
              state_nxt_s    = ST_REQ;
            end
          end else if (!buf_valid_r && imem_ack) begin
            buf_data_nxt_s  = imem_rdata;
            buf_pc_nxt_s    = fetch_pc_r;
            buf_valid_nxt_s = 1'b1;
            fetch_pc_nxt_s  = fetch_pc_r + PC_ONE;
            state_nxt_s     = ST_FULL;
          end else begin
            state_nxt_s = ST_FULL;
          end
`else
          if (consume_s) begin
            ir_valid_nxt_s = 1'b0;
            state_nxt_s    = ST_REQ;
          end else begin
            state_nxt_s = ST_FULL;
          end
`endif
        end

        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      pc_out_r   <= RESET_PC;
      ir_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      pc_out_r   <= pc_out_nxt_s;
      ir_valid_r <= ir_valid_nxt_s;
    end
  end

`ifdef FETCH_PREFETCH_BUF_EN
  // Prefetch buffer registers; only the valid bit needs a reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_r <= 1'b0;
      buf_data_r  <= 16'h0000;
      buf_pc_r    <= RESET_PC;
    end else begin
      buf_valid_r <= buf_valid_nxt_s;
      buf_data_r  <= buf_data_nxt_s;
      buf_pc_r    <= buf_pc_nxt_s;
    end
  end
`endif

  assign imem_req  = imem_req_s;
  assign imem_addr = fetch_pc_r;
  assign ir_wen    = ir_wen_s;
  assign ir_data   = ir_data_s;
  assign ir_valid  = ir_valid_r;
  assign pc_out    = pc_out_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Self-checking bench for fetch_ctrl (default build, no prefetch buffer).
// The reference model describes the fetcher at transaction level: IR is either
// empty or holds one instruction; while it is empty (and not in the single
// post-reset cycle) the fetcher requests the word at the fetch PC. Memory
// returns word_at(addr) for any address. A second instance with
// RESET_PC=16'hFFFF exercises PC wraparound.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [15:0] NOP = 16'h4300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        dec_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        ir_wen;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic [15:0] pc_out;

  logic        w_imem_req;
  logic [15:0] w_imem_addr;
  logic        w_ir_wen;
  logic [15:0] w_ir_data;
  logic        w_ir_valid;
  logic [15:0] w_pc_out;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic        m_idle;
  logic        m_valid;
  logic [15:0] m_fetch;
  logic [15:0] m_pc;
  logic        e_req;
  logic        e_wen;
  logic [15:0] e_data;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .NOP_INST(16'h4300)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_wen(ir_wen), .ir_data(ir_data), .ir_valid(ir_valid), .pc_out(pc_out),
    .dec_ready(dec_ready), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_ctrl #(.PC_W(16), .RESET_PC(16'hFFFF), .NOP_INST(16'h4300)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_wen(w_ir_wen), .ir_data(w_ir_data), .ir_valid(w_ir_valid), .pc_out(w_pc_out),
    .dec_ready(dec_ready), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Drive one cycle of inputs at the falling edge and form model expectations.
  task automatic apply(input logic rst, input logic ack, input logic rdy,
                       input logic stl, input logic rdr, input logic [15:0] rpc);
    @(negedge clk);
    reset       = rst;
    imem_ack    = ack;
    dec_ready   = rdy;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_rdata  = word_at(imem_addr);
    #1;
    e_req  = !m_idle && !m_valid;
    e_wen  = !m_idle && (rdr || (e_req && ack));
    e_data = rdr ? NOP : word_at(m_fetch);
  endtask

  // Advance the model by the current inputs, then let the clock edge happen.
  task automatic tick();
    logic consume;
    consume = m_valid && dec_ready && !stall;
    if (reset) begin
      m_idle = 1'b1; m_valid = 1'b0; m_fetch = 16'h0000; m_pc = 16'h0000;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (redirect) begin
      m_fetch = redirect_pc; m_valid = 1'b0;
    end else if (e_req && imem_ack) begin
      m_valid = 1'b1; m_pc = m_fetch; m_fetch = m_fetch + 16'd1;
    end else if (consume) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_vec++; if (ir_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b exp=0", ir_wen); end
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
    n_vec++; if (pc_out !== 16'h0000) begin n_err++; $display("FAIL reset_pc_out got=%h exp=0000", pc_out); end
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
    tick();
  endtask

  task automatic test_stream();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (ir_wen === 1'b1) pulses++;
      n_vec++; if (ir_wen !== e_wen) begin n_err++; $display("FAIL stream_wen i=%0d got=%b exp=%b", i, ir_wen, e_wen); end
      n_vec++; if (imem_req !== e_req) begin n_err++; $display("FAIL stream_req i=%0d got=%b exp=%b", i, imem_req, e_req); end
      if (i == 1) begin
        n_vec++; if (imem_addr !== 16'h0000 || ir_data !== word_at(16'h0000)) begin
          n_err++; $display("FAIL stream_first addr=%h data=%h exp addr=0000 data=%h", imem_addr, ir_data, word_at(16'h0000)); end
      end
      if (i == 2) begin
        n_vec++; if (ir_valid !== 1'b1 || pc_out !== 16'h0000) begin
          n_err++; $display("FAIL stream_ir valid=%b pc=%h exp valid=1 pc=0000", ir_valid, pc_out); end
      end
      if (i == 3) begin
        n_vec++; if (imem_addr !== 16'h0001) begin n_err++; $display("FAIL stream_addr1 got=%h exp=0001", imem_addr); end
      end
      tick();
    end
    n_vec++; if (pulses != 5) begin n_err++; $display("FAIL stream_rate got=%0d exp=5", pulses); end
  endtask

  task automatic test_stall();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      n_vec++; if (ir_valid !== 1'b1 || ir_wen !== 1'b0 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold i=%0d valid=%b wen=%b req=%b exp 1/0/0", i, ir_valid, ir_wen, imem_req); end
      tick();
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (imem_addr !== 16'h0001 || ir_wen !== 1'b1) begin
      n_err++; $display("FAIL stall_refetch addr=%h wen=%b exp 0001/1", imem_addr, ir_wen); end
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (pc_out !== 16'h0001) begin n_err++; $display("FAIL stall_pc_out got=%h exp=0001", pc_out); end
    tick();
  endtask

  task automatic test_delayed_ack();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, (i == 3), 1'b0, 1'b0, 1'b0, 16'h0000);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || ir_wen !== (i == 3)) begin
        n_err++; $display("FAIL delay_ack i=%0d req=%b addr=%h wen=%b", i, imem_req, imem_addr, ir_wen); end
      tick();
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL delay_valid got=%b exp=1", ir_valid); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100);
    n_vec++; if (ir_wen !== 1'b1 || ir_data !== 16'h4300) begin
      n_err++; $display("FAIL redir_squash wen=%b data=%h exp 1/4300", ir_wen, ir_data); end
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (ir_valid !== 1'b0 || imem_addr !== 16'h0100 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL redir_refetch valid=%b addr=%h req=%b exp 0/0100/1", ir_valid, imem_addr, imem_req); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (w_imem_addr !== 16'hFFFF || w_imem_req !== 1'b1) begin
      n_err++; $display("FAIL wrap_first addr=%h req=%b exp FFFF/1", w_imem_addr, w_imem_req); end
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (w_imem_addr !== 16'h0000 || w_pc_out !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_second addr=%h pc=%h exp 0000/FFFF", w_imem_addr, w_pc_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555); tick();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0555) begin
      n_err++; $display("FAIL midrst_before req=%b addr=%h exp 1/0555", imem_req, imem_addr); end
    tick();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== 16'h0000 || ir_wen !== 1'b0) begin
      n_err++; $display("FAIL midrst_after req=%b valid=%b addr=%h wen=%b exp 0/0/0000/0", imem_req, ir_valid, imem_addr, ir_wen); end
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL midrst_req got=%b exp=1", imem_req); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0), 16'($urandom));
      n_vec++; if (imem_req !== e_req) begin n_err++; $display("FAIL rand_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      n_vec++; if (imem_addr !== m_fetch) begin n_err++; $display("FAIL rand_addr c=%0d got=%h exp=%h", c, imem_addr, m_fetch); end
      n_vec++; if (ir_wen !== e_wen) begin n_err++; $display("FAIL rand_wen c=%0d got=%b exp=%b", c, ir_wen, e_wen); end
      n_vec++; if (ir_valid !== m_valid) begin n_err++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, ir_valid, m_valid); end
      n_vec++; if (pc_out !== m_pc) begin n_err++; $display("FAIL rand_pc_out c=%0d got=%h exp=%h", c, pc_out, m_pc); end
      if (e_wen) begin
        n_vec++; if (ir_data !== e_data) begin n_err++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, ir_data, e_data); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_delayed_ack();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
